// File: rtl/corr_readout.sv
// corr_readout: dumps a correlator accumulator bank as a big-endian byte
// stream (4 bytes per 32-bit word, word 0 first), optionally clearing the
// bank afterwards.
// Optional feature: define CORR_READOUT_HDR_EN to prefix every frame with
// the two header bytes 0xA5, 0x5A. The default build sends data bytes only.
module corr_readout #(
  parameter int ADDR_W  = 6,
  parameter int RD_LAT  = 3,
  parameter int CLR_CYC = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              clr_en,
  output logic              busy,
  output logic              mac_read,
  output logic [ADDR_W-1:0] mac_addr,
  input  logic [31:0]       mac_data,
  output logic              mac_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              out_last
);

  // One counter serves both the read-latency wait and the clear wait.
  localparam int CNT_MAX = (CLR_CYC > RD_LAT) ? CLR_CYC : RD_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]  LAT_LAST  = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0]  CLR_LAST  = CNT_W'(CLR_CYC);
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

`ifdef CORR_READOUT_HDR_EN
  typedef enum logic [2:0] {
    IDLE, RD_ENTER, RD_WAIT, SEND, CLR_GAP, CLR, CLR_WAIT, HDR
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, RD_ENTER, RD_WAIT, SEND, CLR_GAP, CLR, CLR_WAIT
  } state_t;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_q, rd_d;
  logic              clr_q, clr_d;
  logic              clren_q, clren_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       word_q, word_d;
  logic [1:0]        byte_q, byte_d;
  logic              ov_q, ov_d;
  logic [7:0]        od_q, od_d;
  logic              ol_q, ol_d;
  logic              xfer;

  // Big-endian byte select: index 0 is bits 31:24.
  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

  assign xfer      = ov_q & out_ready;
  assign busy      = (state_q != IDLE);
  assign mac_read  = rd_q;
  assign mac_addr  = addr_q;
  assign mac_clr   = clr_q;
  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_last  = ol_q;

  // Next-state and next-output logic; all outputs are registered so the
  // byte stream holds steady while the sink stalls.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    clr_d   = 1'b0;
    clren_d = clren_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    byte_d  = byte_q;
    ov_d    = ov_q;
    od_d    = od_q;
    ol_d    = ol_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          clren_d = clr_en;
          addr_d  = '0;
`ifdef CORR_READOUT_HDR_EN
          // Header goes out before the bank is frozen for reading.
          ov_d    = 1'b1;
          od_d    = 8'hA5;
          ol_d    = 1'b0;
          byte_d  = 2'd0;
          state_d = HDR;
`else
          rd_d    = 1'b1;
          state_d = RD_ENTER;
`endif
        end
      end
`ifdef CORR_READOUT_HDR_EN
      HDR: begin
        if (xfer) begin
          if (byte_q == 2'd0) begin
            byte_d = 2'd1;
            od_d   = 8'h5A;
          end else begin
            ov_d    = 1'b0;
            rd_d    = 1'b1;
            state_d = RD_ENTER;
          end
        end
      end
`endif
      RD_ENTER: begin
        cnt_d   = '0;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (cnt_q == LAT_LAST) begin
          word_d  = mac_data;
          ov_d    = 1'b1;
          od_d    = mac_data[31:24];
          ol_d    = 1'b0;
          byte_d  = 2'd0;
          state_d = SEND;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SEND: begin
        if (xfer) begin
          if (byte_q != 2'd3) begin
            byte_d = byte_q + 2'd1;
            od_d   = byte_sel(word_q, byte_q + 2'd1);
            ol_d   = (byte_q == 2'd2) && (addr_q == ADDR_LAST);
          end else begin
            ov_d = 1'b0;
            ol_d = 1'b0;
            if (addr_q != ADDR_LAST) begin
              addr_d  = addr_q + ADDR_W'(1);
              cnt_d   = '0;
              state_d = RD_WAIT;
            end else begin
              rd_d    = 1'b0;
              state_d = clren_q ? CLR_GAP : IDLE;
            end
          end
        end
      end
      CLR_GAP: begin
        // mac_read is already low; the pulse lands in CLR.
        clr_d   = 1'b1;
        state_d = CLR;
      end
      CLR: begin
        cnt_d   = '0;
        state_d = CLR_WAIT;
      end
      CLR_WAIT: begin
        if (cnt_q == CLR_LAST) state_d = IDLE;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      clr_q   <= 1'b0;
      clren_q <= 1'b0;
      cnt_q   <= '0;
      word_q  <= '0;
      byte_q  <= '0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      ol_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      clr_q   <= clr_d;
      clren_q <= clren_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      byte_q  <= byte_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      ol_q    <= ol_d;
    end
  end

endmodule

// File: doc/corr_readout.md
CORR_READOUT -- requirements
Module: corr_readout

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, accumulator bank address width (2**ADDR_W words).
REQ-002 SHALL have parameter RD_LAT, default 3, clk cycles from mac_addr stable to mac_data valid.
REQ-003 SHALL have parameter CLR_CYC, default 2**ADDR_W, clk cycles the bank needs to complete a clear.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  single-cycle request to dump the whole bank.
REQ-007 clr_en  input  1  sampled with start; 1 = clear bank after dump.
REQ-008 busy  output  1  high from accepted start until return to IDLE.
REQ-009 mac_read  output  1  read enable to accumulator bank, held high for entire dump.
REQ-010 mac_addr  output  ADDR_W  word address to accumulator bank.
REQ-011 mac_data  input  32  registered read data from accumulator bank.
REQ-012 mac_clr  output  1  single-cycle clear request to accumulator bank.
REQ-013 out_valid  output  1  byte stream valid.
REQ-014 out_ready  input  1  byte stream ready from sink.
REQ-015 out_data  output  8  byte stream data.
REQ-016 out_last  output  1  high with final byte of a frame.

Function
REQ-017 States SHALL be IDLE, RD_ENTER, RD_WAIT, SEND, CLR_GAP, CLR, CLR_WAIT (plus HDR per REQ-033).
REQ-018 IDLE: start=1 -> latch clr_en, mac_addr<=0, mac_read<=1, go RD_ENTER; start in any other state ignored.
REQ-019 RD_ENTER: exactly 1 cycle (bank mode entry), then RD_WAIT with latency counter cleared.
REQ-020 RD_WAIT: mac_addr held stable for RD_LAT cycles; on last cycle capture mac_data into 32-bit word register, go SEND.
REQ-021 SEND: emit captured word as 4 bytes MSB first (bits 31:24 first); a byte transfers on out_valid & out_ready; out_data/out_valid SHALL not change while out_valid=1 and out_ready=0.
REQ-022 After 4th byte: if mac_addr != all-ones, increment mac_addr and go RD_WAIT; else deassert mac_read and go CLR_GAP if latched clr_en=1, otherwise IDLE.
REQ-023 out_last SHALL be high only on 4th byte of word 2**ADDR_W-1 (or per REQ-034).
REQ-024 mac_read SHALL stay high continuously RD_ENTER through final SEND byte; mac_addr SHALL not wrap within a frame.
REQ-025 CLR_GAP: 1 cycle with mac_read=0 so bank returns to its wait state; then CLR.
REQ-026 CLR: mac_clr=1 for exactly 1 cycle; then CLR_WAIT.
REQ-027 CLR_WAIT: count CLR_CYC+1 cycles, then IDLE; mac_clr=0 throughout.
REQ-028 busy SHALL be 0 only in IDLE; a start coincident with returning to IDLE SHALL be ignored.
REQ-029 Accumulation in the bank is suspended while mac_read=1; block SHALL never assert mac_read and mac_clr in the same cycle.

Reset
REQ-030 rst_n low SHALL asynchronously force IDLE, busy=0, mac_read=0, mac_addr=0, mac_clr=0, out_valid=0, out_data=0, out_last=0, counters and word register 0.
REQ-031 Reset mid-frame SHALL abort with no further bytes; partial frame is not resumed.

Configuration
REQ-032 Macro CORR_READOUT_HDR_EN SHALL select frame header insertion.
REQ-033 With CORR_READOUT_HDR_EN defined: state HDR inserted between IDLE and RD_ENTER, emitting bytes 0xA5 then 0x5A under the same handshake before any data; mac_read asserted only on leaving HDR.
REQ-034 Without it: no HDR state, frame is exactly 4*2**ADDR_W data bytes; out_last never on header bytes in either build.

Verification
REQ-035 Bank preloaded word[i]=0x01020300+i, out_ready=1, start, clr_en=0 -> 256 bytes 01 02 03 00, 01 02 03 01 ... 01 02 03 3F, out_last on byte 256 only, no mac_clr.
REQ-036 Same with clr_en=1 -> one mac_clr pulse 2 cycles after final byte, busy low CLR_CYC+1 cycles later; re-dump returns all 0x00.
REQ-037 out_ready toggled pseudo-randomly 50% -> byte sequence identical to REQ-035, out_data stable during every stall.
REQ-038 start pulsed at byte 100 of a dump -> ignored, frame length still 256, single frame.
REQ-039 rst_n low at byte 50 -> all outputs 0 next cycle; new start gives full frame from word 0.
REQ-040 With CORR_READOUT_HDR_EN -> frame 258 bytes beginning A5 5A, mac_read low during both header bytes.
